pipe_muxn: RTL and testbench

Parametrised N-way pipeline multiplexer with a registered, valid/ready-handshaked output stage. It selects one of NUM channels of WIDTH bits, tags the result with the chosen channel index, and sustains one transfer per cycle through a two-entry skid buffer. It sits between pipeline stages of the CPU datapath (operand/forwarding selection, writeback source selection) wherever a select must be registered and must honour downstream stall and flush.

---
 rtl/pipe_muxn.sv | 197 +++++++++++++++++++
 tb/tb_pipe_muxn.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_muxn.sv
// -----------------------------------------------------------------------------
// pipe_muxn
//   N-way pipeline multiplexer with a registered valid/ready output stage.
//   One of NUM channels is selected by in_sel, tagged with the channel index
//   and held in a two-entry skid buffer (output register O, skid register S),
//   so one transfer per cycle is sustained while in_ready depends on
//   registered state only.
//
// Parameters
//   WIDTH  data width per channel
//   NUM    number of channels (2..16, need not be a power of two)
//   SEL_W  select width, >= ceil(log2(NUM))
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_data    flattened channels, channel k = in_data[k*WIDTH +: WIDTH]
//   in_sel     channel index
//   in_valid   upstream offers in_data/in_sel
//   in_ready   block accepts this cycle
//   out_data   selected channel (registered)
//   out_sel    index that produced out_data
//   out_valid  out_data/out_sel valid
//   out_ready  downstream accepts this cycle
//   flush      synchronous discard of all held entries
//   sel_err    sticky out-of-range select flag
//
// Build option
//   PIPE_MUXN_SEL_CHECK_EN  when defined, an accepted in_sel >= NUM sets the
//                           sticky sel_err flag (cleared only by rst). When
//                           undefined, sel_err is tied low and no check logic
//                           exists. Out-of-range selects always yield data 0.
// -----------------------------------------------------------------------------
module pipe_muxn #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned NUM   = 4,
   parameter int unsigned SEL_W = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM*WIDTH-1:0]   in_data,
   input  logic [SEL_W-1:0]       in_sel,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [WIDTH-1:0]       out_data,
   output logic [SEL_W-1:0]       out_sel,
   output logic                   out_valid,
   input  logic                   out_ready,
   input  logic                   flush,
   output logic                   sel_err
);

   // Encoding chosen so bit 0 is O.valid and bit 1 is S.valid.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b01,
      ST_FULL  = 2'b11
   } state_t;

   // Returns channel sel, or zero when sel addresses no existing channel.
   function automatic logic [WIDTH-1:0] select_channel(
      input logic [NUM*WIDTH-1:0] data,
      input logic [SEL_W-1:0]     sel
   );
      logic [WIDTH-1:0] res;
      res = {WIDTH{1'b0}};
      for (int unsigned k = 0; k < NUM; k++) begin
         if (sel == SEL_W'(k)) begin
            res = data[k*WIDTH +: WIDTH];
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

   state_t           state_q, state_d;
   logic [WIDTH-1:0] o_data_q, o_data_d;
   logic [SEL_W-1:0] o_sel_q,  o_sel_d;
   logic [WIDTH-1:0] s_data_q, s_data_d;
   logic [SEL_W-1:0] s_sel_q,  s_sel_d;

   logic             accept;
   logic             consume;
   logic [WIDTH-1:0] sel_data;

   // Ready only while the skid slot is free; never looks at out_ready.
   assign in_ready  = ~state_q[1] & ~rst;
   assign out_valid = state_q[0];
   assign out_data  = o_data_q;
   assign out_sel   = o_sel_q;

   assign accept   = in_valid & in_ready;
   assign consume  = state_q[0] & out_ready;
   assign sel_data = select_channel(in_data, in_sel);

   // Next-state and storage update for the two-entry skid buffer.
   always_comb begin
      state_d  = state_q;
      o_data_d = o_data_q;
      o_sel_d  = o_sel_q;
      s_data_d = s_data_q;
      s_sel_d  = s_sel_q;
      if (flush) begin
         // A consume this cycle is already delivered; a coincident accept is dropped.
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  state_d  = ST_ONE;
                  o_data_d = sel_data;
                  o_sel_d  = in_sel;
               end else begin
                  state_d = ST_EMPTY;
               end
            end
            ST_ONE: begin
               if (accept && consume) begin
                  state_d  = ST_ONE;
                  o_data_d = sel_data;
                  o_sel_d  = in_sel;
               end else if (accept) begin
                  state_d  = ST_FULL;
                  s_data_d = sel_data;
                  s_sel_d  = in_sel;
               end else if (consume) begin
                  state_d = ST_EMPTY;
               end else begin
                  state_d = ST_ONE;
               end
            end
            ST_FULL: begin
               if (consume) begin
                  state_d  = ST_ONE;
                  o_data_d = s_data_q;
                  o_sel_d  = s_sel_q;
               end else begin
                  state_d = ST_FULL;
               end
            end
            default: begin
               state_d = ST_EMPTY;
            end
         endcase
      end
   end

   // State and datapath registers; reset overrides flush and traffic.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_EMPTY;
         o_data_q <= {WIDTH{1'b0}};
         o_sel_q  <= {SEL_W{1'b0}};
         s_data_q <= {WIDTH{1'b0}};
         s_sel_q  <= {SEL_W{1'b0}};
      end else begin
         state_q  <= state_d;
         o_data_q <= o_data_d;
         o_sel_q  <= o_sel_d;
         s_data_q <= s_data_d;
         s_sel_q  <= s_sel_d;
      end
   end

`ifdef PIPE_MUXN_SEL_CHECK_EN
   logic sel_err_q, sel_err_d;

   // True when sel addresses an existing channel.
   function automatic logic sel_in_range(input logic [SEL_W-1:0] sel);
      return (32'(sel) < NUM);
   endfunction

   // Sticky flag: any accepted out-of-range select latches it; flush does not clear it.
   always_comb begin
      if (accept && !sel_in_range(in_sel)) begin
         sel_err_d = 1'b1;
      end else begin
         sel_err_d = sel_err_q;
      end
   end

   // Error flag register, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         sel_err_q <= 1'b0;
      end else begin
         sel_err_q <= sel_err_d;
      end
   end

   assign sel_err = sel_err_q;
`else
   assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_muxn.sv
// -----------------------------------------------------------------------------
// tb_pipe_muxn
//   Drives a NUM=4 and a NUM=3 instance of pipe_muxn with identical handshake
//   stimulus. A reference queue holds the entries the model expects to be in
//   flight; entries are pushed on accept and popped/compared on consume.
// -----------------------------------------------------------------------------
module tb_pipe_muxn;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         out_ready;
   logic         flush;
   logic [1:0]   in_sel;
   logic [127:0] in_data;

   logic         in_ready4, out_valid4, sel_err4;
   logic [31:0]  out_data4;
   logic [1:0]   out_sel4;
   logic         in_ready3, out_valid3, sel_err3;
   logic [31:0]  out_data3;
   logic [1:0]   out_sel3;

   typedef struct packed {
      logic [31:0] d4;
      logic [31:0] d3;
      logic [1:0]  sel;
   } entry_t;

   entry_t       sb_q[$];
   int           n_checks = 0;
   int           n_errors = 0;
   logic         selerr_m = 1'b0;
   logic         prev_rst = 1'b1;
   logic [127:0] chans;

   always #5 clk = ~clk;

   pipe_muxn #(.WIDTH(32), .NUM(4), .SEL_W(2)) dut4 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel),
      .in_valid(in_valid), .in_ready(in_ready4), .out_data(out_data4),
      .out_sel(out_sel4), .out_valid(out_valid4), .out_ready(out_ready),
      .flush(flush), .sel_err(sel_err4)
   );

   pipe_muxn #(.WIDTH(32), .NUM(3), .SEL_W(2)) dut3 (
      .clk(clk), .rst(rst), .in_data(in_data[95:0]), .in_sel(in_sel),
      .in_valid(in_valid), .in_ready(in_ready3), .out_data(out_data3),
      .out_sel(out_sel3), .out_valid(out_valid3), .out_ready(out_ready),
      .flush(flush), .sel_err(sel_err3)
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock cycle: check registered state, drive inputs, update the model.
   task automatic step(input logic r, input logic v, input logic [1:0] s,
                       input logic [127:0] d, input logic ordy, input logic fl);
      entry_t e;
      logic   m_ready;
      logic   m_cons;
      logic   m_acc;
      logic   expect_err3;
      @(negedge clk);
      check_eq("out_valid4", {63'd0, out_valid4}, {63'd0, sb_q.size() > 0});
      check_eq("out_valid3", {63'd0, out_valid3}, {63'd0, sb_q.size() > 0});
      if (sb_q.size() > 0) begin
         check_eq("held_data4", {32'd0, out_data4}, {32'd0, sb_q[0].d4});
         check_eq("held_sel4",  {62'd0, out_sel4},  {62'd0, sb_q[0].sel});
         check_eq("held_data3", {32'd0, out_data3}, {32'd0, sb_q[0].d3});
         check_eq("held_sel3",  {62'd0, out_sel3},  {62'd0, sb_q[0].sel});
      end
      if (prev_rst) begin
         check_eq("rst_data4", {32'd0, out_data4}, 64'd0);
         check_eq("rst_sel4",  {62'd0, out_sel4},  64'd0);
         check_eq("rst_data3", {32'd0, out_data3}, 64'd0);
      end
`ifdef PIPE_MUXN_SEL_CHECK_EN
      expect_err3 = selerr_m;
`else
      expect_err3 = 1'b0;
`endif
      check_eq("sel_err3", {63'd0, sel_err3}, {63'd0, expect_err3});
      check_eq("sel_err4", {63'd0, sel_err4}, 64'd0);

      rst       = r;
      in_valid  = v;
      in_sel    = s;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      #1;
      m_ready = !r && (sb_q.size() < 2);
      check_eq("in_ready4", {63'd0, in_ready4}, {63'd0, m_ready});
      check_eq("in_ready3", {63'd0, in_ready3}, {63'd0, m_ready});
      m_cons = (sb_q.size() > 0) && ordy;
      m_acc  = m_ready && v;
      if (m_cons) begin
         e = sb_q.pop_front();
         check_eq("deliver_data4", {32'd0, out_data4}, {32'd0, e.d4});
         check_eq("deliver_sel4",  {62'd0, out_sel4},  {62'd0, e.sel});
         check_eq("deliver_data3", {32'd0, out_data3}, {32'd0, e.d3});
      end
      if (r) begin
         sb_q.delete();
         selerr_m = 1'b0;
      end else begin
         if (m_acc && (s == 2'd3)) selerr_m = 1'b1;
         if (fl) begin
            sb_q.delete();
         end else if (m_acc) begin
            e.d4  = d[int'(s)*32 +: 32];
            e.d3  = (s == 2'd3) ? 32'd0 : d[int'(s)*32 +: 32];
            e.sel = s;
            sb_q.push_back(e);
         end
      end
      prev_rst = r;
   endtask

   initial begin
      chans     = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
      rst       = 1'b1;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      flush     = 1'b0;
      in_sel    = 2'd0;
      in_data   = chans;

      // Reset held three cycles with traffic offered: nothing accepted.
      repeat (3) step(1'b1, 1'b1, 2'd1, chans, 1'b1, 1'b0);

      // Streaming, one accept per cycle, no bubbles.
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'(i), chans, 1'b1, 1'b0);
      repeat (2) step(1'b0, 1'b0, 2'd0, chans, 1'b1, 1'b0);

      // Backpressure: two stalled cycles reach FULL, then drain in order.
      step(1'b0, 1'b1, 2'd0, chans, 1'b1, 1'b0);
      step(1'b0, 1'b1, 2'd1, chans, 1'b0, 1'b0);
      step(1'b0, 1'b1, 2'd2, chans, 1'b0, 1'b0);
      step(1'b0, 1'b1, 2'd3, chans, 1'b0, 1'b0);
      step(1'b0, 1'b1, 2'd3, chans, 1'b1, 1'b0);
      repeat (4) step(1'b0, 1'b0, 2'd0, chans, 1'b1, 1'b0);

      // Flush from FULL with a coincident offer.
      step(1'b0, 1'b1, 2'd0, chans, 1'b0, 1'b0);
      step(1'b0, 1'b1, 2'd1, chans, 1'b0, 1'b0);
      step(1'b0, 1'b1, 2'd2, chans, 1'b0, 1'b1);
      step(1'b0, 1'b1, 2'd3, chans, 1'b1, 1'b0);
      repeat (2) step(1'b0, 1'b0, 2'd0, chans, 1'b1, 1'b0);

      // Out-of-range select on the 3-channel instance, sticky through flush.
      step(1'b0, 1'b1, 2'd3, chans, 1'b1, 1'b0);
      step(1'b0, 1'b0, 2'd0, chans, 1'b1, 1'b0);
      step(1'b0, 1'b1, 2'd0, chans, 1'b0, 1'b1);
      repeat (2) step(1'b0, 1'b0, 2'd0, chans, 1'b1, 1'b0);
      step(1'b1, 1'b0, 2'd0, chans, 1'b1, 1'b0);
      repeat (2) step(1'b0, 1'b0, 2'd0, chans, 1'b1, 1'b0);

      // Random traffic against the reference queue.
      for (int i = 0; i < 10000; i++) begin
         step($urandom_range(0, 999) == 0,
              $urandom_range(0, 3) != 0,
              2'($urandom_range(0, 3)),
              {$urandom, $urandom, $urandom, $urandom},
              $urandom_range(0, 3) != 0,
              $urandom_range(0, 49) == 0);
      end
      repeat (3) step(1'b0, 1'b0, 2'd0, chans, 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
